// File: rtl/mem_access_unit.sv
// Load/store execution stage: one data-memory bus transaction per operation, followed by
// optional pointer and load-data writeback through the register file write port.
module mem_access_unit #(
    parameter int REG_WIDTH = 16,
    parameter int REG_COUNT = 8,
    parameter int WAIT_MAX  = 15,
    localparam int RA_W     = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_store,
    input  logic                 byte_op,
    input  logic [1:0]           addr_mode,
    input  logic [RA_W-1:0]      base_reg,
    input  logic [RA_W-1:0]      data_reg,
    input  logic [REG_WIDTH-1:0] base_val,
    input  logic [REG_WIDTH-1:0] store_val,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [1:0]           mem_be,
    output logic [REG_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [REG_WIDTH-1:0] mem_rdata,
    output logic [1:0]           rf_wr_en,
    output logic [RA_W-1:0]      rf_wr_addr,
    output logic [REG_WIDTH-1:0] rf_wr_data,
    output logic [2:0]           state_dbg
);

    localparam int HALF = REG_WIDTH / 2;
    localparam int WC_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BUS     = 3'd1,
        S_WB_PTR  = 3'd2,
        S_WB_DATA = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                 state;
    logic [WC_W-1:0]        wait_cnt;
    logic                   is_store_q;
    logic                   byte_q;
    logic [1:0]             mode_q;
    logic [RA_W-1:0]        base_reg_q;
    logic [RA_W-1:0]        data_reg_q;
    logic [REG_WIDTH-1:0]   new_ptr_q;
    logic [REG_WIDTH-1:0]   load_q;

    logic [REG_WIDTH-1:0]   size;
    logic [REG_WIDTH-1:0]   ea_next;
    logic [REG_WIDTH-1:0]   ptr_next;
    logic                   misaligned;

    assign state_dbg = state;

    always_comb begin
        size     = byte_op ? REG_WIDTH'(1) : REG_WIDTH'(2);
        ea_next  = base_val;
        ptr_next = base_val;
        case (addr_mode)
            2'b01: ptr_next = base_val + size;
            2'b10: ptr_next = base_val - size;
            2'b11: begin
                ea_next  = base_val - size;
                ptr_next = base_val - size;
            end
            default: ;
        endcase
        misaligned = !byte_op && ea_next[0];
    end

    // Byte loads return the addressed lane zero-extended into the low half.
    function automatic logic [REG_WIDTH-1:0] load_fmt(input logic [REG_WIDTH-1:0] rdata,
                                                      input logic is_byte,
                                                      input logic hi_lane);
        logic [HALF-1:0] lane;
        lane = hi_lane ? rdata[REG_WIDTH-1:HALF] : rdata[HALF-1:0];
        return is_byte ? {{(REG_WIDTH-HALF){1'b0}}, lane} : rdata;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            is_store_q <= 1'b0;
            byte_q     <= 1'b0;
            mode_q     <= 2'b00;
            base_reg_q <= '0;
            data_reg_q <= '0;
            new_ptr_q  <= '0;
            load_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 2'b00;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rf_wr_en   <= 2'b00;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
        end else begin
            done       <= 1'b0;
            err        <= 1'b0;
            rf_wr_en   <= 2'b00;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        wait_cnt   <= '0;
                        is_store_q <= is_store;
                        byte_q     <= byte_op;
                        mode_q     <= addr_mode;
                        base_reg_q <= base_reg;
                        data_reg_q <= data_reg;
                        new_ptr_q  <= ptr_next;
                        if (misaligned) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= S_BUS;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= ea_next;
                            mem_be    <= byte_op ? (ea_next[0] ? 2'b10 : 2'b01) : 2'b11;
                            mem_wdata <= byte_op ? {2{store_val[HALF-1:0]}} : store_val;
                        end
                    end
                end
                S_BUS: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= 2'b00;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        load_q    <= load_fmt(mem_rdata, byte_q, mem_addr[0]);
                        if (mode_q != 2'b00) begin
                            state      <= S_WB_PTR;
                            rf_wr_en   <= 2'b11;
                            rf_wr_addr <= base_reg_q;
                            rf_wr_data <= new_ptr_q;
                        end else if (!is_store_q) begin
                            state      <= S_WB_DATA;
                            rf_wr_en   <= byte_q ? 2'b01 : 2'b11;
                            rf_wr_addr <= data_reg_q;
                            rf_wr_data <= load_fmt(mem_rdata, byte_q, mem_addr[0]);
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Abandon the bus cycle; neither pointer nor data is written back.
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= 2'b00;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        state     <= S_DONE;
                        done      <= 1'b1;
                        err       <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB_PTR: begin
                    if (!is_store_q) begin
                        state      <= S_WB_DATA;
                        rf_wr_en   <= byte_q ? 2'b01 : 2'b11;
                        rf_wr_addr <= data_reg_q;
                        rf_wr_data <= load_q;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_WB_DATA: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: bus responder, register-file write scoreboard and
// per-operation latency/error/bus-field checks against hand-computed values.
module tb_mem_access_unit;
    localparam int W  = 16;
    localparam int RA = 3;
    localparam int EW = 2 + RA + W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, is_store, byte_op;
    logic [1:0]    addr_mode;
    logic [RA-1:0] base_reg, data_reg;
    logic [W-1:0]  base_val, store_val;
    logic          busy, done, err, mem_req, mem_we, mem_ack;
    logic [1:0]    mem_be, rf_wr_en;
    logic [W-1:0]  mem_addr, mem_wdata, mem_rdata, rf_wr_data;
    logic [RA-1:0] rf_wr_addr;
    logic [2:0]    state_dbg;

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    // Bus responder and bus-field capture.
    int           resp_after = -1;
    logic [W-1:0] resp_rdata = '0;
    int           req_cnt    = 0;
    int           req_hi     = 0;
    logic         unstable   = 1'b0;
    logic [W-1:0] bus_addr, bus_wdata;
    logic [1:0]   bus_be;
    logic         bus_we;

    mem_access_unit #(.REG_WIDTH(W), .REG_COUNT(8), .WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .byte_op(byte_op),
        .addr_mode(addr_mode), .base_reg(base_reg), .data_reg(data_reg),
        .base_val(base_val), .store_val(store_val), .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rf(input logic [1:0] en, input logic [RA-1:0] a, input logic [W-1:0] d);
        exp_q.push_back({en, a, d});
    endtask

    always @(negedge clk) begin
        if (mem_req) begin
            if (req_cnt == 0) begin
                bus_addr  = mem_addr;
                bus_be    = mem_be;
                bus_we    = mem_we;
                bus_wdata = mem_wdata;
            end else if (mem_addr !== bus_addr || mem_be !== bus_be ||
                         mem_we !== bus_we || mem_wdata !== bus_wdata) begin
                unstable = 1'b1;
            end
            mem_ack   = (resp_after >= 0 && req_cnt == resp_after);
            mem_rdata = mem_ack ? resp_rdata : '0;
            req_cnt++;
            req_hi++;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = '0;
            req_cnt   = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst && rf_wr_en != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("rf_unexpected", {11'd0, rf_wr_en, rf_wr_addr, rf_wr_data}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rf_wr", {11'd0, rf_wr_en, rf_wr_addr, rf_wr_data}, {11'd0, mon_e});
            end
        end
    end

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_req"}, mem_req, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_be"}, mem_be, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_rfen"}, rf_wr_en, 0);
        chk({tag, "_rfaddr"}, rf_wr_addr, 0);
        chk({tag, "_rfdata"}, rf_wr_data, 0);
        chk({tag, "_state"}, state_dbg, 0);
    endtask

    // Issue one operation from IDLE (called just after a rising edge) and wait for done.
    task automatic run_op(input string tag, input logic st, input logic bo, input logic [1:0] mode,
                          input logic [RA-1:0] breg, input logic [RA-1:0] dreg,
                          input logic [W-1:0] bval, input logic [W-1:0] sval,
                          input logic [W-1:0] rdata, input int ack_after,
                          input int exp_lat, input logic exp_err, input logic pulse);
        int lat;
        req_hi     = 0;
        unstable   = 1'b0;
        resp_after = ack_after;
        resp_rdata = rdata;
        is_store   = st;
        byte_op    = bo;
        addr_mode  = mode;
        base_reg   = breg;
        data_reg   = dreg;
        base_val   = bval;
        store_val  = sval;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, "_busy_acc"}, busy, 1);
        lat = 1;
        @(negedge clk);
        while (!done && lat < 60) begin
            if (pulse) begin
                start    = (lat == 4 || lat == 5);
                base_val = 16'h0777;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_busy_done"}, busy, 1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_rf_pending"}, exp_q.size(), 0);
        chk({tag, "_stable"}, unstable, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_store = 1'b0; byte_op = 1'b0; addr_mode = 2'b00;
        base_reg = '0; data_reg = '0; base_val = '0; store_val = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;

        // Load word direct: done 3 edges after accept.
        push_rf(2'b11, 3'd2, 16'hBEEF);
        run_op("ld_w_dir", 1'b0, 1'b0, 2'b00, 3'd1, 3'd2, 16'h0100, 16'h0, 16'hBEEF, 0, 3, 1'b0, 1'b0);
        chk("ld_w_dir_addr", bus_addr, 16'h0100);
        chk("ld_w_dir_be", bus_be, 2'b11);
        chk("ld_w_dir_we", bus_we, 0);
        chk("ld_w_dir_reqs", req_hi, 1);

        // Store byte post-inc at odd address: high lane, pointer writeback only.
        push_rf(2'b11, 3'd3, 16'h0204);
        run_op("st_b_inc", 1'b1, 1'b1, 2'b01, 3'd3, 3'd5, 16'h0203, 16'h12A5, 16'h0, 0, 3, 1'b0, 1'b0);
        chk("st_b_inc_addr", bus_addr, 16'h0203);
        chk("st_b_inc_be", bus_be, 2'b10);
        chk("st_b_inc_we", bus_we, 1);
        chk("st_b_inc_wdata", bus_wdata, 16'hA5A5);

        // Load word pre-dec wrapping below zero, data_reg == base_reg.
        push_rf(2'b11, 3'd4, 16'hFFFE);
        push_rf(2'b11, 3'd4, 16'h5A3C);
        run_op("ld_w_pre", 1'b0, 1'b0, 2'b11, 3'd4, 3'd4, 16'h0000, 16'h0, 16'h5A3C, 0, 4, 1'b0, 1'b0);
        chk("ld_w_pre_addr", bus_addr, 16'hFFFE);
        chk("ld_w_pre_be", bus_be, 2'b11);

        // Misaligned word load: no bus cycle, done+err after one edge.
        run_op("ld_w_mis", 1'b0, 1'b0, 2'b00, 3'd1, 3'd2, 16'h0101, 16'h0, 16'h0, 0, 1, 1'b1, 1'b0);
        chk("ld_w_mis_reqs", req_hi, 0);

        // Timeout: no ack ever; start pulses mid-operation are ignored.
        run_op("timeout", 1'b0, 1'b0, 2'b01, 3'd1, 3'd2, 16'h0300, 16'h0, 16'h0, -1, 16, 1'b1, 1'b1);
        chk("timeout_reqs", req_hi, 15);
        repeat (3) @(negedge clk);
        chk("timeout_idle_state", state_dbg, 0);
        chk("timeout_no_new_req", req_hi, 15);
        @(posedge clk);
        #1;

        // Byte load post-dec with two wait cycles, high lane selected.
        push_rf(2'b11, 3'd5, 16'h0010);
        push_rf(2'b01, 3'd6, 16'h007E);
        run_op("ld_b_dec", 1'b0, 1'b1, 2'b10, 3'd5, 3'd6, 16'h0011, 16'h0, 16'h7E81, 2, 6, 1'b0, 1'b0);
        chk("ld_b_dec_be", bus_be, 2'b10);
        chk("ld_b_dec_reqs", req_hi, 3);

        // Byte load direct, even address: low lane.
        push_rf(2'b01, 3'd7, 16'h0081);
        run_op("ld_b_dir", 1'b0, 1'b1, 2'b00, 3'd0, 3'd7, 16'h0022, 16'h0, 16'h7E81, 0, 3, 1'b0, 1'b0);
        chk("ld_b_dir_be", bus_be, 2'b01);

        // Reset during BUS aborts the operation.
        req_hi = 0; resp_after = -1;
        is_store = 1'b1; byte_op = 1'b0; addr_mode = 2'b01; base_reg = 3'd2;
        base_val = 16'h0040; store_val = 16'h1234; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_req", mem_req, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_quiet("rst_mid");
        repeat (2) @(negedge clk);
        chk("rst_mid_still_idle", state_dbg, 0);
        @(posedge clk);
        #1;

        // New operation accepted after the abort: store word direct, latency 2.
        run_op("st_w_dir", 1'b1, 1'b0, 2'b00, 3'd2, 3'd3, 16'h0040, 16'h1234, 16'h0, 0, 2, 1'b0, 1'b0);
        chk("st_w_dir_addr", bus_addr, 16'h0040);
        chk("st_w_dir_be", bus_be, 2'b11);
        chk("st_w_dir_wdata", bus_wdata, 16'h1234);
        chk("st_w_dir_we", bus_we, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
